ibex_msg_router: RTL and testbench

Shared message-delivery fabric for a multi-core Ibex cluster. It buffers each core's custom message output (valid, address, length, data and three message words) in a per-core FIFO. It arbitrates round-robin among the buffered messages and delivers at most one message per cycle to the destination core's custom message input. It sits between the `ibex_top_tracing` instances and owns the only path between their message ports.

---
 rtl/ibex_msg_router.sv | 176 +++++++++++++++++
 tb/tb_ibex_msg_router.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_msg_router.sv
// Message fabric between cluster cores: per-source FIFOs, round-robin arbitration and
// a registered one-hot delivery port that carries at most one message per cycle.
module ibex_msg_router #(
  parameter int unsigned NumCores  = 4,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCores-1:0]    src_valid_i,
  input  logic [NumCores*5-1:0]  src_addr_i,
  input  logic [NumCores*2-1:0]  src_len_i,
  input  logic [NumCores*32-1:0] src_data_i,
  input  logic [NumCores*32-1:0] src_msg1_i,
  input  logic [NumCores*32-1:0] src_msg2_i,
  input  logic [NumCores*32-1:0] src_msg3_i,
  output logic [NumCores-1:0]    dst_valid_o,
  output logic [4:0]             dst_addr_o,
  output logic [1:0]             dst_len_o,
  output logic [31:0]            dst_data_o,
  output logic [31:0]            dst_msg1_o,
  output logic [31:0]            dst_msg2_o,
  output logic [31:0]            dst_msg3_o,
  input  logic                   clear_i,
  output logic [NumCores-1:0]    overflow_o,
  output logic [NumCores-1:0]    bad_dest_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int unsigned IdxW  = $clog2(NumCores);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DropW = $clog2(NumCores + 1);

  typedef struct packed {
    logic [4:0]  dest;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] msg1;
    logic [31:0] msg2;
    logic [31:0] msg3;
  } entry_t;

  logic [NumCores-1:0] not_empty;
  logic [NumCores-1:0] gnt;
  logic [NumCores-1:0] drop_bad;
  logic [NumCores-1:0] drop_ovf;
  entry_t              head [NumCores];
  entry_t              sel_head;

  logic                gnt_valid;
  logic [IdxW-1:0]     gnt_idx;
  logic [IdxW-1:0]     cand;
  logic [IdxW-1:0]     rr_q, rr_d;

  logic [DropW-1:0]    n_drop;
  logic [16:0]         cnt_sum;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [NumCores-1:0] ovf_q, ovf_d;
  logic [NumCores-1:0] bad_q, bad_d;

  logic [NumCores-1:0] dst_valid_q, dst_valid_d;
  logic [4:0]          dst_addr_q;
  entry_t              dst_q;

  for (genvar i = 0; i < NumCores; i++) begin : g_src
    entry_t          mem_q [FifoDepth];
    entry_t          in_e;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            bad, full, push, pop;

    assign in_e = {src_addr_i[i*5 +: 5], src_len_i[i*2 +: 2], src_data_i[i*32 +: 32],
                   src_msg1_i[i*32 +: 32], src_msg2_i[i*32 +: 32], src_msg3_i[i*32 +: 32]};

    // A full FIFO still accepts when its head is popped in the same cycle.
    assign bad  = src_valid_i[i] && (in_e.dest >= 5'(NumCores));
    assign full = (cnt_q == CntW'(FifoDepth));
    assign pop  = gnt[i];
    assign push = src_valid_i[i] && !bad && (!full || pop);

    assign drop_bad[i]  = bad;
    assign drop_ovf[i]  = src_valid_i[i] && !bad && full && !pop;
    assign not_empty[i] = (cnt_q != '0);
    assign head[i]      = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
        else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_e;
    end
  end

  // Round-robin search from rr_q; scanning downward lets the nearest requester win.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    gnt       = '0;
    for (int k = NumCores - 1; k >= 0; k--) begin
      cand = IdxW'((int'(rr_q) + k) % int'(NumCores));
      if (not_empty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_valid) gnt = NumCores'(1) << gnt_idx;
  end

  assign sel_head = head[gnt_idx];

  always_comb begin
    rr_d        = rr_q;
    dst_valid_d = '0;
    if (gnt_valid) begin
      rr_d        = (gnt_idx == IdxW'(NumCores - 1)) ? '0 : gnt_idx + IdxW'(1);
      dst_valid_d = NumCores'(1) << sel_head.dest;
    end
  end

  // Clear wipes history, but drops of the clearing cycle are still recorded.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NumCores; i++) begin
      n_drop = n_drop + DropW'(drop_bad[i] | drop_ovf[i]);
    end
    cnt_sum    = 17'(clear_i ? 16'h0000 : drop_cnt_q) + 17'(n_drop);
    drop_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    ovf_d      = (clear_i ? '0 : ovf_q) | drop_ovf;
    bad_d      = (clear_i ? '0 : bad_q) | drop_bad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= '0;
      bad_q       <= '0;
      dst_valid_q <= '0;
      dst_addr_q  <= '0;
      dst_q       <= '0;
    end else begin
      rr_q        <= rr_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      dst_valid_q <= dst_valid_d;
      if (gnt_valid) begin
        dst_addr_q <= 5'(gnt_idx);
        dst_q      <= sel_head;
      end
    end
  end

  assign dst_valid_o = dst_valid_q;
  assign dst_addr_o  = dst_addr_q;
  assign dst_len_o   = dst_q.len;
  assign dst_data_o  = dst_q.data;
  assign dst_msg1_o  = dst_q.msg1;
  assign dst_msg2_o  = dst_q.msg2;
  assign dst_msg3_o  = dst_q.msg3;
  assign overflow_o  = ovf_q;
  assign bad_dest_o  = bad_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_ibex_msg_router.sv
// Directed bench for ibex_msg_router: latency, round-robin order, overflow,
// full-plus-dequeue, bad destination with clear, and reset mid-operation.
module tb_ibex_msg_router;

  localparam int NC = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NC-1:0]   src_valid_i;
  logic [NC*5-1:0] src_addr_i;
  logic [NC*2-1:0] src_len_i;
  logic [NC*32-1:0] src_data_i, src_msg1_i, src_msg2_i, src_msg3_i;
  logic [NC-1:0]   dst_valid_o;
  logic [4:0]      dst_addr_o;
  logic [1:0]      dst_len_o;
  logic [31:0]     dst_data_o, dst_msg1_o, dst_msg2_o, dst_msg3_o;
  logic            clear_i;
  logic [NC-1:0]   overflow_o, bad_dest_o;
  logic [15:0]     drop_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]    addr;
    logic [NC-1:0] valid;
    logic [31:0]   data;
  } dlv_t;
  dlv_t log_q[$];

  ibex_msg_router #(.NumCores(NC), .FifoDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .src_valid_i(src_valid_i), .src_addr_i(src_addr_i), .src_len_i(src_len_i),
    .src_data_i(src_data_i), .src_msg1_i(src_msg1_i), .src_msg2_i(src_msg2_i),
    .src_msg3_i(src_msg3_i),
    .dst_valid_o(dst_valid_o), .dst_addr_o(dst_addr_o), .dst_len_o(dst_len_o),
    .dst_data_o(dst_data_o), .dst_msg1_o(dst_msg1_o), .dst_msg2_o(dst_msg2_o),
    .dst_msg3_o(dst_msg3_o),
    .clear_i(clear_i), .overflow_o(overflow_o), .bad_dest_o(bad_dest_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Every delivery is logged mid-cycle for order checks.
  always @(negedge clk_i) begin
    if (dst_valid_o != '0) log_q.push_back('{dst_addr_o, dst_valid_o, dst_data_o});
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    src_valid_i = '0;
    clear_i     = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [4:0] d, input logic [1:0] l,
                         input logic [31:0] dat, input logic [31:0] m1,
                         input logic [31:0] m2, input logic [31:0] m3);
    src_valid_i[i]          = 1'b1;
    src_addr_i[i*5 +: 5]    = d;
    src_len_i[i*2 +: 2]     = l;
    src_data_i[i*32 +: 32]  = dat;
    src_msg1_i[i*32 +: 32]  = m1;
    src_msg2_i[i*32 +: 32]  = m2;
    src_msg3_i[i*32 +: 32]  = m3;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    tick();
    tick();
    rst_ni = 1'b1;
    log_q.delete();
  endtask

  task automatic rr_burst(input string tag);
    for (int i = 0; i < NC; i++) set_src(i, 5'd0, 2'd0, 32'h100 + i, 0, 0, 0);
    tick();
    idle();
    check_eq({tag, "_idle"}, 64'(dst_valid_o), 64'h0);
    for (int k = 0; k < NC; k++) begin
      tick();
      check_eq({tag, "_valid"}, 64'(dst_valid_o), 64'h1);
      check_eq({tag, "_addr"}, 64'(dst_addr_o), 64'(k));
      check_eq({tag, "_data"}, 64'(dst_data_o), 64'h100 + 64'(k));
    end
    tick();
    check_eq({tag, "_done"}, 64'(dst_valid_o), 64'h0);
  endtask

  initial begin
    logic [31:0] exp0 [6];
    logic [31:0] got0 [$];

    rst_ni      = 1'b0;
    src_valid_i = '0;
    src_addr_i  = '0;
    src_len_i   = '0;
    src_data_i  = '0;
    src_msg1_i  = '0;
    src_msg2_i  = '0;
    src_msg3_i  = '0;
    clear_i     = 1'b0;
    #2;
    check_eq("rst_valid", 64'(dst_valid_o), 64'h0);
    check_eq("rst_data", 64'(dst_data_o), 64'h0);
    check_eq("rst_drop", 64'(drop_cnt_o), 64'h0);
    check_eq("rst_flags", 64'({overflow_o, bad_dest_o}), 64'h0);

    // Single message: two-cycle latency, one-cycle strobe.
    do_reset();
    set_src(1, 5'd2, 2'd3, 32'hA5A5_0001, 32'h11, 32'h22, 32'h33);
    tick();
    idle();
    check_eq("single_e0", 64'(dst_valid_o), 64'h0);
    tick();
    check_eq("single_valid", 64'(dst_valid_o), 64'h4);
    check_eq("single_addr", 64'(dst_addr_o), 64'h1);
    check_eq("single_len", 64'(dst_len_o), 64'h3);
    check_eq("single_data", 64'(dst_data_o), 64'hA5A5_0001);
    check_eq("single_msg1", 64'(dst_msg1_o), 64'h11);
    check_eq("single_msg2", 64'(dst_msg2_o), 64'h22);
    check_eq("single_msg3", 64'(dst_msg3_o), 64'h33);
    tick();
    check_eq("single_off", 64'(dst_valid_o), 64'h0);
    check_eq("single_hold", 64'(dst_data_o), 64'hA5A5_0001);

    // Round-robin: two identical bursts both drain 0,1,2,3.
    do_reset();
    rr_burst("rr1");
    rr_burst("rr2");

    // Overflow and full-plus-dequeue: cores 1..3 prefill, core 0 streams to dest 3.
    // Core 0 is granted at p=7 and p=11; p=9 and p=12 find it full and ungranted.
    do_reset();
    for (int p = 0; p <= 12; p++) begin
      idle();
      if (p <= 3) for (int i = 1; i < NC; i++) set_src(i, 5'd0, 2'd1, 32'hB000 + p, 0, 0, 0);
      if (p >= 4 && p <= 9) set_src(0, 5'd3, 2'd2, 32'hC000_0000 + p - 4, 0, 0, 0);
      if (p == 11) set_src(0, 5'd3, 2'd2, 32'hC000_0006, 0, 0, 0);
      if (p == 12) set_src(0, 5'd3, 2'd2, 32'hC000_0007, 0, 0, 0);
      tick();
    end
    idle();
    for (int k = 0; k < 30; k++) tick();
    check_eq("ovf_flag", 64'(overflow_o), 64'h1);
    check_eq("ovf_bad", 64'(bad_dest_o), 64'h0);
    check_eq("ovf_drops", 64'(drop_cnt_o), 64'h2);
    exp0 = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
             32'hC000_0004, 32'hC000_0006};
    foreach (log_q[j]) begin
      if (log_q[j].addr == 5'd0) begin
        got0.push_back(log_q[j].data);
        check_eq("ovf_dst", 64'(log_q[j].valid), 64'h8);
      end
    end
    check_eq("ovf_count", 64'(got0.size()), 64'd6);
    for (int j = 0; j < 6 && j < got0.size(); j++) check_eq("ovf_order", 64'(got0[j]), 64'(exp0[j]));
    check_eq("ovf_total", 64'(log_q.size()), 64'd18);

    // Bad destination, then clear in the same cycle as another bad send.
    do_reset();
    set_src(2, 5'd7, 2'd0, 32'hDEAD, 0, 0, 0);
    tick();
    idle();
    check_eq("bad_flag", 64'(bad_dest_o), 64'h4);
    check_eq("bad_cnt", 64'(drop_cnt_o), 64'h1);
    for (int k = 0; k < 4; k++) tick();
    check_eq("bad_nodlv", 64'(log_q.size()), 64'd0);
    set_src(2, 5'd7, 2'd0, 32'hDEAD, 0, 0, 0);
    clear_i = 1'b1;
    tick();
    idle();
    check_eq("clr_bad_flag", 64'(bad_dest_o), 64'h4);
    check_eq("clr_bad_cnt", 64'(drop_cnt_o), 64'h1);
    clear_i = 1'b1;
    tick();
    idle();
    check_eq("clr_flag", 64'(bad_dest_o), 64'h0);
    check_eq("clr_cnt", 64'(drop_cnt_o), 64'h0);

    // Reset mid-operation with three messages still queued.
    do_reset();
    set_src(2, 5'd9, 2'd0, 32'h0, 0, 0, 0);
    tick();
    idle();
    for (int i = 0; i < NC; i++) set_src(i, 5'd3, 2'd1, 32'hE000 + i, 0, 0, 0);
    tick();
    idle();
    tick();
    check_eq("mid_pre_valid", 64'(dst_valid_o), 64'h8);
    check_eq("mid_pre_cnt", 64'(drop_cnt_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_valid", 64'(dst_valid_o), 64'h0);
    check_eq("mid_data", 64'(dst_data_o), 64'h0);
    check_eq("mid_addr", 64'(dst_addr_o), 64'h0);
    check_eq("mid_err", 64'({bad_dest_o, drop_cnt_o}), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    log_q.delete();
    for (int k = 0; k < 8; k++) tick();
    check_eq("mid_nodlv", 64'(log_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
